// File: rtl/string_pkg.sv
// ---------------------------------------------------------------------------
// string_pkg
// Shared definitions for the serial string interface. This covers the
// serializer (transmit end) and the detector-side blocks.
//
// Contents:
//   - 2-bit state encodings IDLE/SHIFT/GAP/DONE, shared with detector blocks
//   - default build constants for string width, gap length and counter widths
// ---------------------------------------------------------------------------
package string_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t GAP   = 2'd2;
  localparam state_t DONE  = 2'd3;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_LEN_W      = 4;
  localparam int DEFAULT_REP_W      = 4;
  localparam int DEFAULT_GAP_CYCLES = 2;

endpackage

// File: rtl/string_serializer.sv
// ---------------------------------------------------------------------------
// string_serializer
// Serial bit-string transmitter. It accepts a parallel word through a
// valid/ready handshake and shifts the active field out MSB-first, one bit
// per clock. The word can optionally be repeated, with GAP_CYCLES idle
// cycles between repetitions.
//
// Parameters:
//   WIDTH       maximum string length in bits
//   LEN_W       width of load_len (2**LEN_W must exceed WIDTH)
//   REP_W       width of load_rep
//   GAP_CYCLES  idle cycles between repetitions (0 = back-to-back)
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous reset, active low
//   load_valid  request to load a new string
//   load_ready  a load can be accepted this cycle (IDLE and no abort)
//   load_data   string; active field is load_data[len-1:0]
//   load_len    bit count; 0 or >WIDTH selects WIDTH
//   load_rep    extra repetitions; total transmissions = load_rep+1
//   abort       synchronous cancel of the current transfer
//   seq_out     serial data bit; 0 whenever seq_valid is 0
//   seq_valid   seq_out carries a string bit this cycle
//   busy        state is not IDLE
//   done        one-cycle pulse following the final bit of the final repetition
// ---------------------------------------------------------------------------
module string_serializer
  import string_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int LEN_W      = DEFAULT_LEN_W,
  parameter int REP_W      = DEFAULT_REP_W,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic [REP_W-1:0] load_rep,
  input  logic             abort,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             busy,
  output logic             done
);

  // The gap counter holds GAP_CYCLES-1 down to 0. It keeps a width of at
  // least one bit so that a GAP_CYCLES=0 build still elaborates.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   data_q,  data_n;
  logic [LEN_W-1:0]   len_q,   len_n;
  logic [LEN_W-1:0]   bit_q,   bit_n;
  logic [REP_W-1:0]   rep_q,   rep_n;
  logic [GAP_W-1:0]   gap_q,   gap_n;
  logic [LEN_W-1:0]   eff_len;
  logic               accept;

  logic               seq_out_n;
  logic               seq_valid_n;
  logic               busy_n;
  logic               done_n;

  // A zero length or a length larger than the register means "use the whole word".
  always_comb begin
    if ((load_len == '0) || (load_len > LEN_W'(WIDTH))) begin
      eff_len = LEN_W'(WIDTH);
    end else begin
      eff_len = load_len;
    end
  end

  // Abort takes priority over a simultaneous load request while idle.
  assign load_ready = (state_q == IDLE) && !abort;
  assign accept     = load_valid && load_ready;

  // Next-state logic. The word register is only written on acceptance, so
  // every repetition resends the same bits. The rep counter only decrements
  // while it is non-zero, so it cannot wrap.
  always_comb begin
    state_n = state_q;
    data_n  = data_q;
    len_n   = len_q;
    bit_n   = bit_q;
    rep_n   = rep_q;
    gap_n   = gap_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          data_n  = load_data;
          len_n   = eff_len;
          bit_n   = eff_len - LEN_W'(1);
          rep_n   = load_rep;
        end
      end

      SHIFT: begin
        if (abort) begin
          state_n = IDLE;
        end else if (bit_q != '0) begin
          bit_n = bit_q - LEN_W'(1);
        end else if (rep_q != '0) begin
          rep_n = rep_q - REP_W'(1);
          if (GAP_CYCLES > 0) begin
            state_n = GAP;
            gap_n   = GAP_W'(GAP_CYCLES - 1);
          end else begin
            bit_n = len_q - LEN_W'(1);
          end
        end else begin
          state_n = DONE;
        end
      end

      GAP: begin
        if (abort) begin
          state_n = IDLE;
        end else if (gap_q == '0) begin
          state_n = SHIFT;
          bit_n   = len_q - LEN_W'(1);
        end else begin
          gap_n = gap_q - GAP_W'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // The outputs are derived from the next state so that their registered
  // copies line up with the state they describe. This makes the first bit
  // appear in the cycle right after acceptance.
  always_comb begin
    seq_valid_n = (state_n == SHIFT);
    seq_out_n   = seq_valid_n && (|(data_n & (WIDTH'(1) << bit_n)));
    busy_n      = (state_n != IDLE);
    done_n      = (state_n == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      len_q     <= '0;
      bit_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      seq_out   <= 1'b0;
      seq_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      data_q    <= data_n;
      len_q     <= len_n;
      bit_q     <= bit_n;
      rep_q     <= rep_n;
      gap_q     <= gap_n;
      seq_out   <= seq_out_n;
      seq_valid <= seq_valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_string_serializer.sv
// ---------------------------------------------------------------------------
// tb_string_serializer
// Directed bench for string_serializer. It uses a GAP_CYCLES=2 instance
// ("g2") and a GAP_CYCLES=0 instance ("g0"). Each output stream feeds a
// small registered 1001 detector model.
// ---------------------------------------------------------------------------
module tb_string_serializer;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;
  localparam int REP_W = 4;

  logic             clock;
  logic             reset;
  logic             load_valid_g2, load_valid_g0;
  logic             load_ready_g2, load_ready_g0;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic [REP_W-1:0] load_rep;
  logic             abort;
  logic             seq_out_g2, seq_out_g0;
  logic             seq_valid_g2, seq_valid_g0;
  logic             busy_g2, busy_g0;
  logic             done_g2, done_g0;

  int compared   = 0;
  int mismatched = 0;

  string_serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .GAP_CYCLES(2)) dut_g2 (
    .clock(clock), .reset(reset),
    .load_valid(load_valid_g2), .load_ready(load_ready_g2),
    .load_data(load_data), .load_len(load_len), .load_rep(load_rep),
    .abort(abort),
    .seq_out(seq_out_g2), .seq_valid(seq_valid_g2),
    .busy(busy_g2), .done(done_g2)
  );

  string_serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .GAP_CYCLES(0)) dut_g0 (
    .clock(clock), .reset(reset),
    .load_valid(load_valid_g0), .load_ready(load_ready_g0),
    .load_data(load_data), .load_len(load_len), .load_rep(load_rep),
    .abort(abort),
    .seq_out(seq_out_g0), .seq_valid(seq_valid_g0),
    .busy(busy_g0), .done(done_g0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered 1001 detector model. It only looks at valid bits, and it
  // fires in the cycle after the last bit of a match.
  logic [2:0] hist_g2, hist_g0;
  logic       det_g2,  det_g0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_g2 <= '0; det_g2 <= 1'b0;
      hist_g0 <= '0; det_g0 <= 1'b0;
    end else begin
      det_g2 <= seq_valid_g2 && ({hist_g2, seq_out_g2} == 4'b1001);
      det_g0 <= seq_valid_g0 && ({hist_g0, seq_out_g0} == 4'b1001);
      if (seq_valid_g2) hist_g2 <= {hist_g2[1:0], seq_out_g2};
      if (seq_valid_g0) hist_g0 <= {hist_g0[1:0], seq_out_g0};
    end
  end

  // Observations from the most recent transfer.
  logic [31:0] bits;
  int nbits, busy_cycles, done_count, done_cycle, gap_cycles, det_count, det_cycle, zero_viol;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // This task pulses a load on one instance and then watches the transfer
  // until busy drops or the cycle budget runs out. The current cycle after
  // the acceptance edge counts as cycle 1.
  task automatic applyStimulus(input bit use_g0, input logic [WIDTH-1:0] d,
                               input logic [LEN_W-1:0] l, input logic [REP_W-1:0] r,
                               input int max_cycles);
    logic b, v, s, dn, dt;
    int cyc;
    bits = '0; nbits = 0; busy_cycles = 0; done_count = 0; done_cycle = 0;
    gap_cycles = 0; det_count = 0; det_cycle = 0; zero_viol = 0;
    load_data = d; load_len = l; load_rep = r;
    if (use_g0) load_valid_g0 = 1'b1; else load_valid_g2 = 1'b1;
    tick();
    load_valid_g0 = 1'b0;
    load_valid_g2 = 1'b0;
    cyc = 0;
    b = 1'b1;
    while (cyc < max_cycles) begin
      cyc++;
      b  = use_g0 ? busy_g0      : busy_g2;
      v  = use_g0 ? seq_valid_g0 : seq_valid_g2;
      s  = use_g0 ? seq_out_g0   : seq_out_g2;
      dn = use_g0 ? done_g0      : done_g2;
      dt = use_g0 ? det_g0       : det_g2;
      if (!b) break;
      busy_cycles++;
      if (v) begin
        bits = {bits[30:0], s};
        nbits++;
      end else if (s) begin
        zero_viol++;
      end
      if (!v && !dn) gap_cycles++;
      if (dn) begin
        done_count++;
        done_cycle = cyc;
      end
      if (dt) begin
        det_count++;
        if (det_cycle == 0) det_cycle = cyc;
      end
      tick();
    end
    checkOutput("transfer_ends_in_budget", 32'(b), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    load_valid_g2 = 1'b0;
    load_valid_g0 = 1'b0;
    load_data = '0; load_len = '0; load_rep = '0;
    abort = 1'b0;
    #12;
    checkOutput("reset_seq_out",    32'(seq_out_g2),    32'd0);
    checkOutput("reset_seq_valid",  32'(seq_valid_g2),  32'd0);
    checkOutput("reset_busy",       32'(busy_g2),       32'd0);
    checkOutput("reset_done",       32'(done_g2),       32'd0);
    checkOutput("reset_load_ready", 32'(load_ready_g2), 32'd1);
    reset = 1'b1;
    tick();

    // Single 1001, no repetition
    applyStimulus(1'b0, 8'h09, 4'd4, 4'd0, 40);
    checkOutput("t1_bits",       bits,               32'h9);
    checkOutput("t1_nbits",      32'(nbits),         32'd4);
    checkOutput("t1_busy",       32'(busy_cycles),   32'd5);
    checkOutput("t1_done_count", 32'(done_count),    32'd1);
    checkOutput("t1_done_cycle", 32'(done_cycle),    32'd5);
    checkOutput("t1_det_count",  32'(det_count),     32'd1);
    checkOutput("t1_det_cycle",  32'(det_cycle),     32'd5);
    checkOutput("t1_zero_out",   32'(zero_viol),     32'd0);
    tick();

    // Three bursts separated by 2-cycle gaps: busy = 3*4 + 2*2 + 1
    applyStimulus(1'b0, 8'h09, 4'd4, 4'd2, 60);
    checkOutput("t2_bits",       bits,               32'h999);
    checkOutput("t2_nbits",      32'(nbits),         32'd12);
    checkOutput("t2_busy",       32'(busy_cycles),   32'd17);
    checkOutput("t2_gaps",       32'(gap_cycles),    32'd4);
    checkOutput("t2_done_count", 32'(done_count),    32'd1);
    checkOutput("t2_done_cycle", 32'(done_cycle),    32'd17);
    checkOutput("t2_zero_out",   32'(zero_viol),     32'd0);
    tick();

    // Back-to-back repetition with no gap
    applyStimulus(1'b1, 8'h09, 4'd4, 4'd1, 40);
    checkOutput("t3_bits",       bits,               32'h99);
    checkOutput("t3_nbits",      32'(nbits),         32'd8);
    checkOutput("t3_busy",       32'(busy_cycles),   32'd9);
    checkOutput("t3_gaps",       32'(gap_cycles),    32'd0);
    checkOutput("t3_det_count",  32'(det_count),     32'd2);
    checkOutput("t3_done_count", 32'(done_count),    32'd1);
    tick();

    // load_len = 0 means the full width
    applyStimulus(1'b0, 8'hA5, 4'd0, 4'd0, 40);
    checkOutput("t4_len0_bits",  bits,               32'hA5);
    checkOutput("t4_len0_nbits", 32'(nbits),         32'd8);
    checkOutput("t4_len0_busy",  32'(busy_cycles),   32'd9);
    tick();

    // load_len > WIDTH also means the full width
    applyStimulus(1'b0, 8'hA5, 4'd12, 4'd0, 40);
    checkOutput("t4_len12_bits",  bits,              32'hA5);
    checkOutput("t4_len12_nbits", 32'(nbits),        32'd8);
    tick();

    // Single-bit string
    applyStimulus(1'b0, 8'h01, 4'd1, 4'd0, 40);
    checkOutput("t4_len1_bits",  bits,               32'h1);
    checkOutput("t4_len1_nbits", 32'(nbits),         32'd1);
    checkOutput("t4_len1_busy",  32'(busy_cycles),   32'd2);
    checkOutput("t4_len1_done",  32'(done_cycle),    32'd2);
    tick();

    // All-ones rep gives 16 transmissions: busy = 16*1 + 15*2 + 1
    applyStimulus(1'b0, 8'h01, 4'd1, 4'hF, 100);
    checkOutput("t4_rep_max_nbits", 32'(nbits),       32'd16);
    checkOutput("t4_rep_max_bits",  bits,             32'hFFFF);
    checkOutput("t4_rep_max_busy",  32'(busy_cycles), 32'd47);
    checkOutput("t4_rep_max_done",  32'(done_count),  32'd1);
    tick();

    // Abort on the 2nd bit
    load_data = 8'h09; load_len = 4'd4; load_rep = 4'd0;
    load_valid_g2 = 1'b1;
    tick();
    load_valid_g2 = 1'b0;
    checkOutput("t5_first_bit",   32'(seq_out_g2),   32'd1);
    tick();
    checkOutput("t5_second_valid", 32'(seq_valid_g2), 32'd1);
    abort = 1'b1;
    tick();
    checkOutput("t5_abort_valid", 32'(seq_valid_g2),  32'd0);
    checkOutput("t5_abort_busy",  32'(busy_g2),       32'd0);
    checkOutput("t5_abort_done",  32'(done_g2),       32'd0);
    checkOutput("t5_ready_abort", 32'(load_ready_g2), 32'd0);
    abort = 1'b0;
    #1;
    checkOutput("t5_ready_after", 32'(load_ready_g2), 32'd1);
    tick();
    checkOutput("t5_no_done",     32'(done_g2),       32'd0);
    abort = 1'b1;
    load_valid_g2 = 1'b1;
    tick();
    load_valid_g2 = 1'b0;
    abort = 1'b0;
    checkOutput("t5_blocked_busy",  32'(busy_g2),      32'd0);
    checkOutput("t5_blocked_valid", 32'(seq_valid_g2), 32'd0);
    tick();

    // Asynchronous reset in the middle of SHIFT
    load_data = 8'h09; load_len = 4'd4; load_rep = 4'd1;
    load_valid_g2 = 1'b1;
    tick();
    load_valid_g2 = 1'b0;
    tick();
    checkOutput("t6_pre_busy", 32'(busy_g2), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6_rst_seq_out",   32'(seq_out_g2),    32'd0);
    checkOutput("t6_rst_seq_valid", 32'(seq_valid_g2),  32'd0);
    checkOutput("t6_rst_busy",      32'(busy_g2),       32'd0);
    checkOutput("t6_rst_done",      32'(done_g2),       32'd0);
    checkOutput("t6_rst_ready",     32'(load_ready_g2), 32'd1);
    #1;
    reset = 1'b1;
    tick();
    applyStimulus(1'b0, 8'h09, 4'd4, 4'd0, 40);
    checkOutput("t6_after_bits",  bits,             32'h9);
    checkOutput("t6_after_nbits", 32'(nbits),       32'd4);
    checkOutput("t6_after_done",  32'(done_count),  32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
